id_stage_pipe: RTL

//  RV64 decode stage with handshake, between fetch and execute.
//  - Decodes opcode/funct fields to one-hot buses and builds the XLEN sign-extended immediate.
//  - Reads the external GPR file and selects the CSR slot.
//  - Detects RAW hazards with a per-register pending-write scoreboard.
//  - Registers the decoded bundle toward EX with a valid/ready handshake.

---
 rtl/id_pkg.sv | 45 ++++
 rtl/id_scoreboard.sv | 65 ++++++
 rtl/id_stage_pipe.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_pkg.sv
// Shared decode constants for the RV64 decode stage: opcodes, one-hot bit
// positions, funct7 patterns, the CSR address map and privileged encodings.
package id_pkg;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;
    localparam logic [6:0] OPC_OPIW  = 7'b0011011;
    localparam logic [6:0] OPC_OPW   = 7'b0111011;

    localparam int OP_LUI   = 0;
    localparam int OP_AUIPC = 1;
    localparam int OP_JAL   = 2;
    localparam int OP_JALR  = 3;
    localparam int OP_BR    = 4;
    localparam int OP_LD    = 5;
    localparam int OP_ST    = 6;
    localparam int OP_OPI   = 7;
    localparam int OP_OP    = 8;
    localparam int OP_SYS   = 9;
    localparam int OP_OPIW  = 10;
    localparam int OP_OPW   = 11;
    localparam int OP_N     = 12;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [5:0] F7H_ZERO  = 6'b000000;
    localparam logic [5:0] F7H_SRA64 = 6'b010000;

    localparam int CSR_N = 4;
    localparam logic [11:0] CSR_ADDR [CSR_N] = '{12'h300, 12'h305, 12'h341, 12'h342};

    localparam logic [31:0] SYS_ECALL  = 32'h0000_0073;
    localparam logic [31:0] SYS_EBREAK = 32'h0010_0073;
    localparam logic [31:0] SYS_MRET   = 32'h3020_0073;

endpackage

// File: rtl/id_scoreboard.sv
// Per-register pending-write counters used by the decode stage to detect
// RAW hazards and to stop a register's counter from overflowing.
module id_scoreboard #(
    parameter int NREG = 32,
    parameter int SB_W = 2,
    localparam int RA_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_en,
    input  logic [RA_W-1:0] inc_addr,
    input  logic            dec_en,
    input  logic [RA_W-1:0] dec_addr,
    input  logic            undo_en,
    input  logic [RA_W-1:0] undo_addr,
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    input  logic [RA_W-1:0] rd_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_full
);

    localparam int CW = SB_W + 2;

    logic [SB_W-1:0] pend_q [NREG];
    logic [SB_W-1:0] pend_d [NREG];
    logic [NREG-1:0] inc_vec, dec_vec, undo_vec;

    // Net change per register; a result below zero means a stray decrement and is clamped.
    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        undo_vec = '0;
        inc_vec[inc_addr]   = inc_en;
        dec_vec[dec_addr]   = dec_en;
        undo_vec[undo_addr] = undo_en;
        for (int r = 0; r < NREG; r++) begin
            if (({2'b00, pend_q[r]} + CW'(inc_vec[r])) >= (CW'(dec_vec[r]) + CW'(undo_vec[r])))
                pend_d[r] = SB_W'({2'b00, pend_q[r]} + CW'(inc_vec[r])
                                  - CW'(dec_vec[r]) - CW'(undo_vec[r]));
            else
                pend_d[r] = '0;
        end
        pend_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always @(posedge clk) begin
        if (rst && dec_en)
            assert (pend_q[dec_addr] != '0 || (inc_en && inc_addr == dec_addr));
    end

    assign rs1_busy = pend_q[rs1_addr] != '0;
    assign rs2_busy = pend_q[rs2_addr] != '0;
    assign rd_full  = pend_q[rd_addr] == '1;

endmodule

// File: rtl/id_stage_pipe.sv
// RV64 decode stage: combinational decode and GPR read, scoreboard hazard
// check, and a registered valid/ready bundle toward execute.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int SB_W = 2,
    parameter int NCSR = 4,
    localparam int RA_W = $clog2(NREG),
    localparam int CI_W = $clog2(NCSR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [RA_W-1:0] rs1_addr,
    output logic [RA_W-1:0] rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [XLEN-1:0] out_imm,
    output logic [RA_W-1:0] out_rd,
    output logic            out_rd_wen,
    output logic [11:0]     out_op_d,
    output logic [7:0]      out_fu3_d,
    output logic [4:0]      out_fu7_d,
    output logic [CI_W-1:0] out_csr_idx,
    output logic [2:0]      out_sys,
    output logic            out_illegal
);

    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic            sgn, uses_rs1, uses_rs2, sys_priv, csr_hit;
    logic [RA_W-1:0] dec_rd;
    logic [11:0]     dec_op;
    logic [7:0]      dec_fu3;
    logic [4:0]      dec_fu7;
    logic [XLEN-1:0] dec_imm;
    logic            dec_rd_wen, dec_illegal;
    logic [CI_W-1:0] dec_csr;
    logic [2:0]      dec_sys;
    logic            hazard, accept, undo_en, rs1_busy, rs2_busy, rd_full;

    logic            valid_q, valid_d, rd_wen_q, rd_wen_d, illegal_q, illegal_d;
    logic [XLEN-1:0] pc_q, pc_d, src1_q, src1_d, src2_q, src2_d, imm_q, imm_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [11:0]     op_q, op_d;
    logic [7:0]      fu3_q, fu3_d;
    logic [4:0]      fu7_q, fu7_d;
    logic [CI_W-1:0] csr_q, csr_d;
    logic [2:0]      sys_q, sys_d;

    assign opcode   = in_inst[6:0];
    assign f3       = in_inst[14:12];
    assign f7       = in_inst[31:25];
    assign sgn      = in_inst[31];
    assign dec_rd   = in_inst[7 +: RA_W];
    assign rs1_addr = in_inst[15 +: RA_W];
    assign rs2_addr = in_inst[20 +: RA_W];

    always_comb begin
        dec_op = '0;
        case (opcode)
            OPC_LUI:   dec_op[OP_LUI]   = 1'b1;
            OPC_AUIPC: dec_op[OP_AUIPC] = 1'b1;
            OPC_JAL:   dec_op[OP_JAL]   = 1'b1;
            OPC_JALR:  dec_op[OP_JALR]  = 1'b1;
            OPC_BR:    dec_op[OP_BR]    = 1'b1;
            OPC_LD:    dec_op[OP_LD]    = 1'b1;
            OPC_ST:    dec_op[OP_ST]    = 1'b1;
            OPC_OPI:   dec_op[OP_OPI]   = 1'b1;
            OPC_OP:    dec_op[OP_OP]    = 1'b1;
            OPC_SYS:   dec_op[OP_SYS]   = 1'b1;
            OPC_OPIW:  dec_op[OP_OPIW]  = 1'b1;
            OPC_OPW:   dec_op[OP_OPW]   = 1'b1;
            default:   dec_op = '0;
        endcase

        dec_imm = '0;
        if (dec_op[OP_LD] | dec_op[OP_JALR] | dec_op[OP_OPI] | dec_op[OP_SYS] | dec_op[OP_OPIW])
            dec_imm = {{(XLEN-12){sgn}}, in_inst[31:20]};
        else if (dec_op[OP_ST])
            dec_imm = {{(XLEN-12){sgn}}, in_inst[31:25], in_inst[11:7]};
        else if (dec_op[OP_BR])
            dec_imm = {{(XLEN-13){sgn}}, sgn, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        else if (dec_op[OP_LUI] | dec_op[OP_AUIPC])
            dec_imm = {{(XLEN-32){sgn}}, in_inst[31:12], 12'h000};
        else if (dec_op[OP_JAL])
            dec_imm = {{(XLEN-21){sgn}}, sgn, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

        dec_fu3  = 8'b1 << f3;
        dec_fu7  = {f7[6:1] == F7H_SRA64, f7[6:1] == F7H_ZERO, f7 == F7_MULDIV, f7 == F7_ALT, f7 == F7_BASE};
        uses_rs1 = !(dec_op[OP_LUI] | dec_op[OP_AUIPC] | dec_op[OP_JAL]);
        uses_rs2 = dec_op[OP_BR] | dec_op[OP_ST] | dec_op[OP_OP] | dec_op[OP_OPW];
        sys_priv = dec_op[OP_SYS] && f3 == 3'b000;

        csr_hit = 1'b0;
        dec_csr = '0;
        if (dec_op[OP_SYS] && !sys_priv) begin
            for (int i = 0; i < NCSR && i < CSR_N; i++) begin
                if (in_inst[31:20] == CSR_ADDR[i]) begin
                    csr_hit = 1'b1;
                    dec_csr = CI_W'(i);
                end
            end
        end

        dec_sys = 3'b000;
        if (sys_priv) begin
            if (in_inst == SYS_MRET)   dec_sys = 3'b100;
            if (in_inst == SYS_ECALL)  dec_sys = 3'b010;
            if (in_inst == SYS_EBREAK) dec_sys = 3'b001;
        end

        dec_illegal = (dec_op == '0) || (dec_op[OP_SYS] && !sys_priv && !csr_hit)
                      || (sys_priv && dec_sys == 3'b000);
        dec_rd_wen  = (dec_rd != '0) && (dec_op != '0) && !dec_op[OP_BR] && !dec_op[OP_ST] && !sys_priv;
    end

    // A held-but-killed bundle never reaches writeback, so its pending count is returned here.
    always_comb begin
        hazard   = (uses_rs1 && rs1_addr != '0 && rs1_busy)
                 || (uses_rs2 && rs2_addr != '0 && rs2_busy)
                 || (dec_rd_wen && rd_full);
        in_ready = (!valid_q || out_ready) && !hazard && !flush;
        accept   = in_valid && in_ready;
        undo_en  = flush && valid_q && !out_ready && rd_wen_q;
    end

    id_scoreboard #(.NREG(NREG), .SB_W(SB_W)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (accept && dec_rd_wen),
        .inc_addr  (dec_rd),
        .dec_en    (wb_valid && wb_rd != '0),
        .dec_addr  (wb_rd),
        .undo_en   (undo_en),
        .undo_addr (rd_q),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rd_addr   (dec_rd),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rd_full   (rd_full)
    );

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        rd_wen_d  = rd_wen_q;
        op_d      = op_q;
        fu3_d     = fu3_q;
        fu7_d     = fu7_q;
        csr_d     = csr_q;
        sys_d     = sys_q;
        illegal_d = illegal_q;
        if (flush)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (out_ready)
            valid_d = 1'b0;
        if (accept) begin
            pc_d      = in_pc;
            src1_d    = rs1_data;
            src2_d    = rs2_data;
            imm_d     = dec_imm;
            rd_d      = dec_rd;
            rd_wen_d  = dec_rd_wen;
            op_d      = dec_op;
            fu3_d     = dec_fu3;
            fu7_d     = dec_fu7;
            csr_d     = dec_csr;
            sys_d     = dec_sys;
            illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            op_q      <= '0;
            fu3_q     <= '0;
            fu7_q     <= '0;
            csr_q     <= '0;
            sys_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            rd_wen_q  <= rd_wen_d;
            op_q      <= op_d;
            fu3_q     <= fu3_d;
            fu7_q     <= fu7_d;
            csr_q     <= csr_d;
            sys_q     <= sys_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_src1    = src1_q;
    assign out_src2    = src2_q;
    assign out_imm     = imm_q;
    assign out_rd      = rd_q;
    assign out_rd_wen  = rd_wen_q;
    assign out_op_d    = op_q;
    assign out_fu3_d   = fu3_q;
    assign out_fu7_d   = fu7_q;
    assign out_csr_idx = csr_q;
    assign out_sys     = sys_q;
    assign out_illegal = illegal_q;

endmodule
